l2_pri_bank_arb: RTL and testbench
==================================

L2_PRI_BANK_ARB -- requirements
Module: l2_pri_bank_arb

Interface
REQ-001 SHALL have parameter NB_MASTERS, default 2, number of requesting TCDM masters (2..8).
REQ-002 SHALL have parameter MAX_WAIT, default 4, denied-request cycles before forced priority (1..15).
REQ-003 SHALL have port clk_i, input, 1, single clock, all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port mst_slave[NB_MASTERS], XBAR_TCDM_BUS_CFI.Slave, interface, master-side requests and responses.
REQ-006 SHALL have port bank_master, XBAR_TCDM_BUS_CFI.Master, interface, to one private L2 bank (1-cycle fixed latency, gnt may be tied to req).
REQ-007 SHALL have port err_o, output, 1, sticky flag: unexpected bank r_valid.

Function
REQ-008 SHALL drive bank_master.req = OR of all mst_slave[i].req, combinationally.
REQ-009 SHALL select exactly one winner per cycle: starved master if any (REQ-013), else first requester at or after rr_ptr, wrapping modulo NB_MASTERS.
REQ-010 SHALL forward winner's add, wen, wdata, be unmodified to bank_master, zero when no request.
REQ-011 SHALL assert mst_slave[winner].gnt = bank_master.gnt; all other gnt = 0; gnt never asserted without req.
REQ-012 SHALL, on each accepted transfer (bank req && gnt), load rr_ptr <= (winner+1) mod NB_MASTERS; rr_ptr unchanged otherwise.
REQ-013 SHALL keep per-master wait counter: +1 (saturating at MAX_WAIT) on req && !gnt, cleared on gnt or !req; master with counter == MAX_WAIT is starved; lowest-index starved master wins.
REQ-014 SHALL register resp_id <= winner and resp_pend <= 1 on accepted transfer, else resp_pend <= 0.
REQ-015 SHALL route bank_master.r_valid and r_opc to mst_slave[resp_id] only, exactly 1 cycle after that master's gnt; other r_valid = 0.
REQ-016 SHALL broadcast bank_master.r_rdata to all mst_slave[i].r_rdata.
REQ-017 SHALL set err_o on bank r_valid while resp_pend = 0; err_o cleared only by reset.
REQ-018 SHALL support back-to-back transfers every cycle, any master mix, with no bubble.
REQ-019 SHALL NOT grant when bank_master.gnt = 0; counters still advance, rr_ptr held.
REQ-020 SHALL, for NB_MASTERS = 1, pass through with rr_ptr constant 0.

Reset
REQ-021 SHALL on rst_i clear rr_ptr, resp_id, resp_pend, all wait counters, err_o, asynchronously.
REQ-022 SHALL drop any in-flight response on reset mid-transfer; no r_valid to any master after reset release until new grant.
REQ-023 SHALL hold all master gnt/r_valid at 0 while rst_i asserted.

Structure
REQ-024 SHALL place winner-select function (rr_ptr, req vector, starved vector -> index) in shared package l2_arb_pkg, with NB_MASTERS_MAX = 8 and id-width typedef.
REQ-025 SHALL use one sub-module l2_arb_wait_cnt (saturating counter) instantiated per master.
REQ-026 SHALL derive data/be widths from CFI_INSTR_WIDTH_DEF and CFI_BEN_DEF.

Verification
REQ-027 Single master 0 read at 0x1C010000 -> gnt same cycle, r_valid at master 0 next cycle, rr_ptr = 1.
REQ-028 Masters 0 and 1 requesting continuously for 6 cycles -> grants 0,1,0,1,0,1, no bubbles, responses routed to matching id.
REQ-029 Bank gnt forced 0 for 5 cycles with master 1 requesting, MAX_WAIT = 4 -> counter saturates at 4, master 1 wins first cycle gnt returns, even if rr_ptr = 0 and master 0 requests.
REQ-030 rst_i pulsed in cycle after gnt to master 0 -> no r_valid to master 0, rr_ptr = 0, err_o = 0.
REQ-031 Bank r_valid injected with no pending grant -> err_o = 1 and stays 1 until reset; no master sees r_valid.
REQ-032 NB_MASTERS = 3, write with be = 4'b0011 from master 2 -> bank sees identical add/wdata/be, master 2 gets r_valid next cycle.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared widths, id type and winner-select function for the L2 bank arbiter
package l2_arb_pkg;
  localparam int NB_MASTERS_MAX = 8;
  localparam int CFI_ADDR_WIDTH = 32;
  localparam int CFI_INSTR_WIDTH_DEF = 32;
  localparam int CFI_BEN_DEF = CFI_INSTR_WIDTH_DEF / 8;
  typedef logic [$clog2(NB_MASTERS_MAX)-1:0] id_t;
  typedef logic [NB_MASTERS_MAX-1:0] mask_t;
  // Lowest-index starved master wins outright, otherwise round-robin from rr_ptr.
  function automatic id_t pick_winner(input id_t rr_ptr, input mask_t req, input mask_t starved,
                                      input int n);
    id_t w;
    logic hit;
    logic [3:0] j;
    w = '0;
    hit = 1'b0;
    for (int i = 0; i < NB_MASTERS_MAX; i++)
      if (!hit && starved[id_t'(i)]) begin
        w = id_t'(i);
        hit = 1'b1;
      end
    for (int k = 0; k < NB_MASTERS_MAX; k++) begin
      j = {1'b0, rr_ptr} + 4'(k);
      j = (j >= 4'(n)) ? j - 4'(n) : j;
      if (!hit && k < n && req[j[2:0]]) begin
        w = j[2:0];
        hit = 1'b1;
      end
    end
    return w;
  endfunction
endpackage

// File: rtl/l2_pri_bank_arb_if.sv
// XBAR_TCDM_BUS_CFI: TCDM request/response bus between masters, arbiter and L2 bank
interface XBAR_TCDM_BUS_CFI;
  import l2_arb_pkg::*;
  logic req;
  logic [CFI_ADDR_WIDTH-1:0] add;
  logic wen;
  logic [CFI_INSTR_WIDTH_DEF-1:0] wdata;
  logic [CFI_BEN_DEF-1:0] be;
  logic gnt;
  logic r_valid;
  logic r_opc;
  logic [CFI_INSTR_WIDTH_DEF-1:0] r_rdata;
  modport Master (output req, add, wen, wdata, be, input gnt, r_valid, r_opc, r_rdata);
  modport Slave (input req, add, wen, wdata, be, output gnt, r_valid, r_opc, r_rdata);
endinterface

// File: rtl/l2_arb_wait_cnt.sv
// l2_arb_wait_cnt: saturating denied-request counter that flags a starved master
module l2_arb_wait_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic starved
);
  logic [3:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (!req || gnt) ? '0 : (cnt == 4'(MAX_WAIT)) ? cnt : cnt + 4'd1;
  assign starved = req && cnt == 4'(MAX_WAIT);
endmodule

// File: rtl/l2_pri_bank_arb.sv
// l2_pri_bank_arb: round-robin arbiter with starvation override onto one private L2 bank
module l2_pri_bank_arb
  import l2_arb_pkg::*;
#(
  parameter int NB_MASTERS = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  XBAR_TCDM_BUS_CFI.Slave         mst_slave [NB_MASTERS],
  XBAR_TCDM_BUS_CFI.Master        bank_master,
  output logic                    err_o
);
  mask_t req, starved, gnt;
  id_t winner, rr_ptr, resp_id;
  logic resp_pend, accept;
  logic [CFI_ADDR_WIDTH-1:0] add [NB_MASTERS];
  logic [CFI_INSTR_WIDTH_DEF-1:0] wdata [NB_MASTERS];
  logic [CFI_BEN_DEF-1:0] be [NB_MASTERS];
  logic [NB_MASTERS-1:0] wen;
  for (genvar i = 0; i < NB_MASTERS_MAX; i++) begin : g_mst
    if (i < NB_MASTERS) begin : g_on
      assign req[i] = mst_slave[i].req;
      assign add[i] = mst_slave[i].add;
      assign wen[i] = mst_slave[i].wen;
      assign wdata[i] = mst_slave[i].wdata;
      assign be[i] = mst_slave[i].be;
      assign gnt[i] = !rst_i && accept && req[i] && winner == id_t'(i);
      assign mst_slave[i].gnt = gnt[i];
      // resp_pend is cleared by reset, so a response in flight at reset is dropped
      assign mst_slave[i].r_valid = resp_pend && resp_id == id_t'(i) && bank_master.r_valid;
      assign mst_slave[i].r_opc = resp_pend && resp_id == id_t'(i) && bank_master.r_opc;
      assign mst_slave[i].r_rdata = bank_master.r_rdata;
      l2_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
        .clk(clk_i), .rst(rst_i), .req(req[i]), .gnt(gnt[i]), .starved(starved[i])
      );
    end else begin : g_off
      assign req[i] = 1'b0;
      assign starved[i] = 1'b0;
      assign gnt[i] = 1'b0;
    end
  end
  assign winner = pick_winner(rr_ptr, req, starved, NB_MASTERS);
  assign bank_master.req = |req;
  assign accept = bank_master.req && bank_master.gnt;
  always_comb begin
    bank_master.add = '0;
    bank_master.wen = 1'b0;
    bank_master.wdata = '0;
    bank_master.be = '0;
    for (int i = 0; i < NB_MASTERS; i++)
      if (req[i] && winner == id_t'(i)) begin
        bank_master.add = add[i];
        bank_master.wen = wen[i];
        bank_master.wdata = wdata[i];
        bank_master.be = be[i];
      end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rr_ptr <= '0;
      resp_id <= '0;
      resp_pend <= 1'b0;
      err_o <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= (winner == id_t'(NB_MASTERS - 1)) ? '0 : winner + id_t'(1);
        resp_id <= winner;
      end
      resp_pend <= accept;
      if (bank_master.r_valid && !resp_pend) err_o <= 1'b1;
    end
endmodule

// File: tb/tb_l2_pri_bank_arb.sv
// tb_l2_pri_bank_arb: scoreboard bench for the L2 bank arbiter with three masters and a 1-cycle bank
module tb_l2_pri_bank_arb;
  import l2_arb_pkg::*;
  typedef struct {
    int id;
    logic [31:0] rd;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [2:0] m_req = '0;
  logic [2:0] m_wen = '1;
  logic [2:0] gnt, rv, opc;
  logic [31:0] m_add [3];
  logic [31:0] m_wdata [3];
  logic [31:0] m_rd [3];
  logic [3:0] m_be [3];
  logic bank_en = 1'b1;
  logic inject = 1'b0;
  logic bk_rv = 1'b0;
  logic [31:0] bk_rd = '0;
  logic err;
  int n_cmp = 0;
  int n_fail = 0;
  exp_t q[$];
  XBAR_TCDM_BUS_CFI mst [3] ();
  XBAR_TCDM_BUS_CFI bank ();
  l2_pri_bank_arb #(.NB_MASTERS(3), .MAX_WAIT(4)) dut (
    .clk_i(clk), .rst_i(rst), .mst_slave(mst), .bank_master(bank), .err_o(err)
  );
  for (genvar g = 0; g < 3; g++) begin : g_m
    assign mst[g].req = m_req[g];
    assign mst[g].add = m_add[g];
    assign mst[g].wen = m_wen[g];
    assign mst[g].wdata = m_wdata[g];
    assign mst[g].be = m_be[g];
    assign gnt[g] = mst[g].gnt;
    assign rv[g] = mst[g].r_valid;
    assign opc[g] = mst[g].r_opc;
    assign m_rd[g] = mst[g].r_rdata;
  end
  // Bank model: fixed 1-cycle read latency, returns inverted address as data, ignores reset
  assign bank.gnt = bank.req && bank_en;
  always @(posedge clk) begin
    bk_rv <= bank.req && bank.gnt;
    bk_rd <= ~bank.add;
  end
  assign bank.r_valid = bk_rv | inject;
  assign bank.r_opc = bk_rv | inject;
  assign bank.r_rdata = bk_rd;

  task automatic test_reset();
    m_req = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b000 || rv !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_hold gnt=%b rvalid=%b expected 000/000", gnt, rv);
    end
    n_cmp++;
    if (bank.req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_bank_req got %b expected 1", bank.req);
    end
    m_req = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0 || bank.req !== 1'b0 || bank.add !== '0 || bank.wen !== 1'b0 || bank.wdata !== '0 || bank.be !== '0) begin
      n_fail++;
      $display("FAIL idle_zero err=%b req=%b add=%h wen=%b wdata=%h be=%h expected all 0", err, bank.req, bank.add, bank.wen, bank.wdata, bank.be);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [2:0] rq [4];
    logic [2:0] tg [4];
    logic [2:0] exp_rv;
    exp_t e;
    int id;
    rq = '{3'b001, 3'b000, 3'b011, 3'b000};
    tg = '{3'b001, 3'b000, 3'b010, 3'b000};
    m_add[0] = 32'h1C01_0000;
    m_add[1] = 32'h1C01_0100;
    for (int c = 0; c < 4; c++) begin
      m_req = rq[c];
      @(negedge clk);
      exp_rv = '0;
      e = '{0, '0};
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_rv[e.id] = 1'b1;
      end
      n_cmp++;
      if (rv !== exp_rv || opc !== exp_rv || (exp_rv != 0 && m_rd[e.id] !== e.rd)) begin
        n_fail++;
        $display("FAIL single_rsp c=%0d rvalid=%b opc=%b rdata=%h expected rvalid=%b rdata=%h", c, rv, opc, m_rd[e.id], exp_rv, e.rd);
      end
      n_cmp++;
      if (gnt !== tg[c]) begin
        n_fail++;
        $display("FAIL single_gnt c=%0d got %b expected %b", c, gnt, tg[c]);
      end
      id = tg[c][2] ? 2 : tg[c][1] ? 1 : 0;
      if (tg[c] != 0) q.push_back('{id, ~m_add[id]});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] tg, exp_rv;
    exp_t e;
    int id;
    for (int c = 0; c < 7; c++) begin
      m_req = (c < 6) ? 3'b011 : 3'b000;
      tg = (c < 6) ? ((c % 2 == 1) ? 3'b010 : 3'b001) : 3'b000;
      m_add[0] = 32'h1C01_1000 + 32'(c) * 4;
      m_add[1] = 32'h1C01_2000 + 32'(c) * 4;
      @(negedge clk);
      exp_rv = '0;
      e = '{0, '0};
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_rv[e.id] = 1'b1;
      end
      n_cmp++;
      if (rv !== exp_rv || opc !== exp_rv || (exp_rv != 0 && m_rd[e.id] !== e.rd)) begin
        n_fail++;
        $display("FAIL b2b_rsp c=%0d rvalid=%b opc=%b rdata=%h expected rvalid=%b rdata=%h", c, rv, opc, m_rd[e.id], exp_rv, e.rd);
      end
      id = tg[1] ? 1 : 0;
      n_cmp++;
      if (gnt !== tg || (tg != 0 && bank.add !== m_add[id])) begin
        n_fail++;
        $display("FAIL b2b_gnt c=%0d gnt=%b add=%h expected gnt=%b add=%h", c, gnt, bank.add, tg, m_add[id]);
      end
      if (tg != 0) q.push_back('{id, ~m_add[id]});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_starve();
    logic [2:0] rq [14];
    logic [2:0] tg [14];
    logic en [14];
    logic [2:0] exp_rv;
    exp_t e;
    int id;
    rq = '{3'b100, 3'b010, 3'b010, 3'b010, 3'b011, 3'b100, 3'b010,
           3'b010, 3'b010, 3'b010, 3'b010, 3'b011, 3'b001, 3'b000};
    en = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tg = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b001, 3'b100, 3'b000,
           3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b000};
    m_add[2] = 32'h1C01_3000;
    for (int c = 0; c < 14; c++) begin
      m_req = rq[c];
      bank_en = en[c];
      @(negedge clk);
      exp_rv = '0;
      e = '{0, '0};
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_rv[e.id] = 1'b1;
      end
      n_cmp++;
      if (rv !== exp_rv || opc !== exp_rv || (exp_rv != 0 && m_rd[e.id] !== e.rd)) begin
        n_fail++;
        $display("FAIL starve_rsp c=%0d rvalid=%b opc=%b rdata=%h expected rvalid=%b rdata=%h", c, rv, opc, m_rd[e.id], exp_rv, e.rd);
      end
      n_cmp++;
      if (gnt !== tg[c]) begin
        n_fail++;
        $display("FAIL starve_gnt c=%0d got %b expected %b", c, gnt, tg[c]);
      end
      id = tg[c][2] ? 2 : tg[c][1] ? 1 : 0;
      if (tg[c] != 0) q.push_back('{id, ~m_add[id]});
      @(posedge clk);
      #1;
    end
    bank_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    m_req = 3'b001;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_gnt got %b expected 001", gnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_req = '0;
    @(negedge clk);
    n_cmp++;
    if (rv !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_rvalid_in_reset got %b expected 000", rv);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_req = 3'b011;
    @(negedge clk);
    n_cmp++;
    if (rv !== 3'b000 || err !== 1'b0 || gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_after_reset rvalid=%b err=%b gnt=%b expected 000/0/001", rv, err, gnt);
    end
    @(posedge clk);
    #1;
    m_req = '0;
    @(negedge clk);
    n_cmp++;
    if (rv !== 3'b001 || m_rd[0] !== ~m_add[0]) begin
      n_fail++;
      $display("FAIL mid_new_rsp rvalid=%b rdata=%h expected 001/%h", rv, m_rd[0], ~m_add[0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_err();
    inject = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rv !== 3'b000 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_stray rvalid=%b err=%b expected 000/0", rv, err);
    end
    @(posedge clk);
    #1 inject = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set got %b expected 1", err);
    end
    @(posedge clk);
    #1 m_req = 3'b010;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b010) begin
      n_fail++;
      $display("FAIL err_gnt got %b expected 010", gnt);
    end
    @(posedge clk);
    #1 m_req = '0;
    @(negedge clk);
    n_cmp++;
    if (rv !== 3'b010 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky rvalid=%b err=%b expected 010/1", rv, err);
    end
    rst = 1'b1;
    #2;
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_async_clear got %b expected 0", err);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_write();
    m_add[2] = 32'h1C02_0040;
    m_wdata[2] = 32'hA5A5_1234;
    m_be[2] = 4'b0011;
    m_wen[2] = 1'b0;
    m_req = 3'b100;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b100) begin
      n_fail++;
      $display("FAIL write_gnt got %b expected 100", gnt);
    end
    n_cmp++;
    if (bank.add !== 32'h1C02_0040 || bank.wdata !== 32'hA5A5_1234 || bank.be !== 4'b0011 || bank.wen !== 1'b0) begin
      n_fail++;
      $display("FAIL write_fwd add=%h wdata=%h be=%b wen=%b expected 1c020040/a5a51234/0011/0", bank.add, bank.wdata, bank.be, bank.wen);
    end
    @(posedge clk);
    #1 m_req = '0;
    @(negedge clk);
    n_cmp++;
    if (rv !== 3'b100 || m_rd[2] !== ~32'h1C02_0040) begin
      n_fail++;
      $display("FAIL write_rsp rvalid=%b rdata=%h expected 100/%h", rv, m_rd[2], ~32'h1C02_0040);
    end
    n_cmp++;
    if (m_rd[0] !== m_rd[2] || m_rd[1] !== m_rd[2]) begin
      n_fail++;
      $display("FAIL rdata_bcast got %h/%h expected %h", m_rd[0], m_rd[1], m_rd[2]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_add[i] = 32'h1C01_0000 + 32'(i) * 32'h100;
      m_wdata[i] = 32'h1111_0000 + 32'(i);
      m_be[i] = 4'hF;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_starve();
    test_reset_mid();
    test_err();
    test_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
endmodule
